// File: rtl/rfblackwidow_dcache_wbuf_if.sv
// Bus interface for the dcache store write buffer.
// Groups the store-capture port, the data-RAM write port and the load
// forwarding port. The master side drives stores, RAM acks and load
// lookups. The slave side is the buffer itself.
interface rfblackwidow_dcache_wbuf_if #(
    parameter int AWID  = 32,
    parameter int DATAW = 256
);
    logic                 wr;
    logic [AWID-1:0]      wadr;
    logic [DATAW-1:0]     wdat;
    logic [DATAW/8-1:0]   wsel;
    logic                 full;
    logic                 empty;
    logic                 ovf;
    logic                 ram_req;
    logic [AWID-1:0]      ram_adr;
    logic [DATAW-1:0]     ram_dat;
    logic [DATAW/8-1:0]   ram_sel;
    logic                 ram_ack;
    logic [AWID-1:0]      ld_adr;
    logic                 fwd_hit;
    logic [DATAW-1:0]     fwd_dat;
    logic [DATAW/8-1:0]   fwd_sel;

    modport master (
        output wr, wadr, wdat, wsel, ram_ack, ld_adr,
        input  full, empty, ovf, ram_req, ram_adr, ram_dat, ram_sel,
               fwd_hit, fwd_dat, fwd_sel
    );

    modport slave (
        input  wr, wadr, wdat, wsel, ram_ack, ld_adr,
        output full, empty, ovf, ram_req, ram_adr, ram_dat, ram_sel,
               fwd_hit, fwd_dat, fwd_sel
    );
endinterface

// File: rtl/rfblackwidow_dcache_wbuf.sv
// Store write buffer sitting behind the dcache write-enable generator.
// Stores are queued as line entries, drained to the data RAM through a
// req/ack handshake, and forwarded to loads so stale RAM data is never used.
// Optional macro RFBW_DCWB_COALESCE_EN merges a store into the youngest entry
// when both target the same line. This happens only if that entry is not the head
// being issued or loaded.
module rfblackwidow_dcache_wbuf #(
    parameter int DEPTH = 4,
    parameter int AWID  = 32,
    parameter int DATAW = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    rfblackwidow_dcache_wbuf_if.slave  bus
);

    localparam int SELW = DATAW / 8;
    localparam int OFS  = $clog2(SELW);
    localparam int LW   = AWID - OFS;
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t            state, state_nxt;

    logic [LW-1:0]     ent_line [DEPTH];
    logic [DATAW-1:0]  ent_dat  [DEPTH];
    logic [SELW-1:0]   ent_sel  [DEPTH];
    logic [DEPTH-1:0]  ent_vld;

    logic [PW-1:0]     wptr, rptr, rptr_nx1;
    logic [CW-1:0]     count, count_nxt;
    logic              full_r, empty_r, ovf_r;

    logic [AWID-1:0]   ram_adr_r;
    logic [DATAW-1:0]  ram_dat_r;
    logic [SELW-1:0]   ram_sel_r;

    logic              pop, alloc, merge, drop, wr_en, load_head;
    logic [PW-1:0]     wr_idx, load_idx;
    logic [LW-1:0]     wline, lline, head_line;
    logic [DATAW-1:0]  wr_dat, head_dat;
    logic [SELW-1:0]   wr_sel, head_sel;

    logic              fwd_hit_c;
    logic [DATAW-1:0]  fwd_dat_c;
    logic [SELW-1:0]   fwd_sel_c;
    logic [PW-1:0]     fidx;

`ifdef RFBW_DCWB_COALESCE_EN
    logic [PW-1:0]     ypt;
    logic [DATAW-1:0]  wmask;
`endif

    assign wline    = bus.wadr[AWID-1:OFS];
    assign lline    = bus.ld_adr[AWID-1:OFS];
    assign rptr_nx1 = rptr + PW'(1);

`ifdef RFBW_DCWB_COALESCE_EN
    // Youngest entry index and byte-expanded store mask for merging
    always_comb begin
        ypt = wptr - PW'(1);
        wmask = '0;
        for (int b = 0; b < SELW; b++) begin
            wmask[b*8 +: 8] = {8{bus.wsel[b]}};
        end
    end
`endif

    // Decide whether a store allocates, merges or is dropped, and what gets written
    always_comb begin
`ifdef RFBW_DCWB_COALESCE_EN
        merge  = bus.wr && (count >= CW'(2)) && (ent_line[ypt] == wline);
        wr_idx = merge ? ypt : wptr;
        wr_dat = merge ? ((ent_dat[ypt] & ~wmask) | (bus.wdat & wmask)) : bus.wdat;
        wr_sel = merge ? (ent_sel[ypt] | bus.wsel) : bus.wsel;
`else
        merge  = 1'b0;
        wr_idx = wptr;
        wr_dat = bus.wdat;
        wr_sel = bus.wsel;
`endif
        alloc     = bus.wr && !merge && (!full_r || pop);
        drop      = bus.wr && !merge && full_r && !pop;
        wr_en     = alloc || merge;
        count_nxt = count + CW'(alloc) - CW'(pop);
    end

    // Drain FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Drain FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count != '0) state_nxt = ISSUE;
            ISSUE:   if (pop && (count_nxt == '0)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Drain FSM outputs: request, pop strobe and head reload control
    always_comb begin
        bus.ram_req = (state == ISSUE);
        pop         = (state == ISSUE) && bus.ram_ack;
        load_head   = ((state == IDLE) && (count != '0)) || (pop && (count_nxt != '0));
        load_idx    = (state == IDLE) ? rptr : rptr_nx1;
    end

    // Head source, bypassing an entry written this same cycle
    always_comb begin
        if (wr_en && (wr_idx == load_idx)) begin
            head_line = wline;
            head_dat  = wr_dat;
            head_sel  = wr_sel;
        end else begin
            head_line = ent_line[load_idx];
            head_dat  = ent_dat[load_idx];
            head_sel  = ent_sel[load_idx];
        end
    end

    // Pointers, occupancy and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            ovf_r   <= 1'b0;
        end else begin
            wptr    <= wptr + PW'(alloc);
            rptr    <= rptr + PW'(pop);
            count   <= count_nxt;
            full_r  <= (count_nxt == CW'(DEPTH));
            empty_r <= (count_nxt == '0);
            ovf_r   <= ovf_r | drop;
        end
    end

    // Entry valid bits; a new allocation wins over a pop of the same slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_vld <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc && (wptr == PW'(i)))     ent_vld[i] <= 1'b1;
                else if (pop && (rptr == PW'(i)))  ent_vld[i] <= 1'b0;
            end
        end
    end

    // Entry payload storage, qualified by the valid bits so no reset needed
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ent_line[wr_idx] <= wline;
            ent_dat[wr_idx]  <= wr_dat;
            ent_sel[wr_idx]  <= wr_sel;
        end
    end

    // RAM write-port registers, reloaded from the head entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_adr_r <= '0;
            ram_dat_r <= '0;
            ram_sel_r <= '0;
        end else if (load_head) begin
            ram_adr_r <= {head_line, {OFS{1'b0}}};
            ram_dat_r <= head_dat;
            ram_sel_r <= head_sel;
        end
    end

    // Load forwarding: scan oldest to youngest so the youngest match wins
    always_comb begin
        fwd_hit_c = 1'b0;
        fwd_dat_c = '0;
        fwd_sel_c = '0;
        fidx      = rptr;
        for (int k = 0; k < DEPTH; k++) begin
            fidx = rptr + PW'(k);
            if (ent_vld[fidx] && (ent_line[fidx] == lline)) begin
                fwd_hit_c = 1'b1;
                fwd_dat_c = ent_dat[fidx];
                fwd_sel_c = ent_sel[fidx];
            end
        end
    end

    assign bus.full    = full_r;
    assign bus.empty   = empty_r;
    assign bus.ovf     = ovf_r;
    assign bus.ram_adr = ram_adr_r;
    assign bus.ram_dat = ram_dat_r;
    assign bus.ram_sel = ram_sel_r;
    assign bus.fwd_hit = fwd_hit_c;
    assign bus.fwd_dat = fwd_dat_c;
    assign bus.fwd_sel = fwd_sel_c;

endmodule

// File: doc/rfblackwidow_dcache_wbuf.md
Name: rfblackwidow_dcache_wbuf

Overview:
- Store write buffer directly downstream of the dcache write-enable generator.
- Captures each single-cycle `wr` pulse together with line address, line data and byte selects into a small FIFO.
- Drains entries to the dcache data-RAM write port with a request/acknowledge handshake.
- Forwards pending store bytes to the load path so loads never read stale RAM contents.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, minimum 2.
- AWID, 32, physical address width; the line index is bits AWID-1:LOG2(DATAW/8).
- DATAW, 256, cache line width in bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- wr  in  1  single-cycle store-write pulse from the write-enable generator.
- wadr  in  AWID  store address; the line is taken from the upper bits.
- wdat  in  DATAW  store data, already aligned within the line.
- wsel  in  DATAW/8  byte enables for wdat.
- full  out  1  buffer holds DEPTH entries.
- empty  out  1  buffer holds zero entries.
- ovf  out  1  sticky flag: a push was dropped; cleared only by reset.
- ram_req  out  1  write request to the data RAM.
- ram_adr  out  AWID  line-aligned address (low bits zero).
- ram_dat  out  DATAW  data presented to the RAM.
- ram_sel  out  DATAW/8  byte enables presented to the RAM.
- ram_ack  in  1  RAM accepted the write this cycle.
- ld_adr  in  AWID  load lookup address.
- fwd_hit  out  1  a valid entry matches the ld_adr line.
- fwd_dat  out  DATAW  data of the youngest matching entry.
- fwd_sel  out  DATAW/8  byte enables of the youngest matching entry.

Behaviour:
- Reset (asynchronous): all entries invalid; read and write pointers 0; count 0; FSM to IDLE.
  - Output reset values: ram_req=0, ram_adr=0, ram_dat=0, ram_sel=0, ovf=0, full=0, empty=1.
  - Reset mid-handshake abandons the write; ram_req drops immediately.
- Push:
  - wr=1 and not full → write the entry at the write pointer (line address, data, sel); set its valid bit; increment the write pointer modulo DEPTH.
  - wr=1 and full, with no pop in the same cycle → push dropped; ovf set to 1.
  - wr=1 and full, with a pop (ram_ack) in the same cycle → push accepted; count unchanged.
- Count: increments on push only, decrements on pop only, unchanged when both occur. full and empty are registered functions of count.
- Drain FSM:
  - IDLE: if count!=0, load ram_adr/ram_dat/ram_sel from the head entry, assert ram_req, go to ISSUE.
  - ISSUE: hold ram_req and all RAM outputs stable until ram_ack.
    - On ram_ack: clear the head valid bit and advance the read pointer.
    - If count after the pop is nonzero, load the next head the same cycle and stay in ISSUE (back-to-back throughput of 1 per cycle).
    - Otherwise deassert ram_req and return to IDLE.
  - ram_ack while ram_req=0 is ignored.
- Latency: a push into an empty, idle buffer gives ram_req=1 two cycles after the wr edge (one cycle to write the entry, one to load the RAM outputs).
- Forwarding (combinational on ld_adr):
  - Compare the ld_adr line against all valid entries, including the head in ISSUE.
  - The youngest match (closest behind the write pointer) supplies fwd_dat and fwd_sel.
  - No match → fwd_hit=0, fwd_dat=0, fwd_sel=0.
  - Merging bytes across multiple matching entries is not performed; the load path stalls on a partial hit.
- Pointer wrap: pointers are LOG2(DEPTH) bits and wrap naturally; full and empty are distinguished by count, not by pointers.

Optional Feature:
- RFBW_DCWB_COALESCE_EN
- Defined: a push whose line equals the youngest valid entry's line is merged into that entry, with two exceptions that instead allocate a new entry:
  - the youngest entry is the head while in ISSUE;
  - the youngest entry is the head in IDLE when count==1, since it is being loaded this cycle.
  - Merge rule: bytes with wsel=1 overwrite; sel is OR-ed. Count, pointers and ovf are unchanged, and a merge into a full buffer is accepted.
- Undefined: every accepted push allocates a new entry; there is no line compare on the push path.

Test Plan:
- Reset, then wr with wadr=0x1040, wsel=0x0000000F, ram_ack tied 1 → ram_req=1 two cycles later with ram_adr=0x1040, ram_sel=0x0000000F; empty=1 the cycle after ack.
- Four pushes to lines 0x000, 0x020, 0x040, 0x060 with ram_ack=0 → full=1; a fifth push leaves ovf=1 and ram_adr still 0x000. Releasing ram_ack gives four consecutive acks in order 0x000, 0x020, 0x040, 0x060.
- With full=1, wr and ram_ack in the same cycle → the new entry is accepted, count stays 4, ovf stays 0.
- Push 0x2000 sel=0x1 data=0xAA, then 0x2000 sel=0x1 data=0xBB, with RAM stalled; ld_adr=0x2008 → fwd_hit=1, byte0 of fwd_dat = 0xBB. ld_adr=0x3000 → fwd_hit=0.
- Assert rst for one cycle while ram_req=1 in ISSUE → ram_req=0 immediately, empty=1, ovf=0; a subsequent push drains normally.
- With the macro defined: two pushes to line 0x4000 (sel 0x1 then 0x2) while another entry is in ISSUE → count increases by 1 only; the drained entry has ram_sel=0x3.
